// File: rtl/noc_stream_injector.sv
// noc_stream_injector
// Streams a programmed SRAM address range into fixed-length NoC packets.
// Each packet is steered round-robin to a free mapper on a per-mapper VC,
// and every flit consumes one downstream credit on that VC at issue time.
// SRAM reads have one cycle of latency; flits leave one cycle after the
// read data arrives, so an issue at cycle t shows up on flit_out at t+2.
module noc_stream_injector #(
    parameter int DATA_WIDTH       = 32,
    parameter int ADDR_WIDTH       = 10,
    parameter int NUM_MAPPERS      = 4,
    parameter int DEST_BITS        = 2,
    parameter int MAPPER_PORT_BASE = 0,
    parameter int NUM_VCS          = 2,
    parameter int VC_BITS          = 1,
    parameter int CREDITS_PER_VC   = 4,
    parameter int PKT_LEN          = 8
) (
    input  logic                                      CLK,
    input  logic                                      RST,
    input  logic                                      start,
    input  logic [ADDR_WIDTH-1:0]                     base_addr,
    input  logic [ADDR_WIDTH:0]                       num_words,
    output logic                                      busy,
    output logic                                      done,
    output logic                                      sram_en,
    output logic [ADDR_WIDTH-1:0]                     sram_addr,
    input  logic [DATA_WIDTH-1:0]                     sram_rdata,
    input  logic [NUM_MAPPERS-1:0]                    mapper_free,
    output logic [2+DEST_BITS+VC_BITS+DATA_WIDTH-1:0] flit_out,
    input  logic [VC_BITS:0]                          get_credit,
    output logic                                      en_get_credit,
    output logic                                      cred_err
);
    localparam int FW  = 2 + DEST_BITS + VC_BITS + DATA_WIDTH;
    localparam int CW  = $clog2(CREDITS_PER_VC + 1);
    localparam int PCW = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
    localparam int MW  = (NUM_MAPPERS > 1) ? $clog2(NUM_MAPPERS) : 1;

    localparam logic [CW-1:0]         CRED_MAX = CW'(CREDITS_PER_VC);
    localparam logic [CW-1:0]         CRED_ONE = CW'(1);
    localparam logic [PCW-1:0]        PKT_LAST = PCW'(PKT_LEN - 1);
    localparam logic [ADDR_WIDTH:0]   WL_ZERO  = {(ADDR_WIDTH+1){1'b0}};
    localparam logic [ADDR_WIDTH:0]   WL_ONE   = {{ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SELECT = 2'd1,
        ST_STREAM = 2'd2,
        ST_DRAIN  = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic [ADDR_WIDTH:0]    words_left_q, words_left_d;
    logic [PCW-1:0]         pkt_cnt_q, pkt_cnt_d;
    logic [MW-1:0]          rr_q, rr_d;
    logic [DEST_BITS-1:0]   dest_q, dest_d;
    logic [VC_BITS-1:0]     vc_q, vc_d;
    logic [CW-1:0]          credit_q [NUM_VCS];
    logic [CW-1:0]          credit_d [NUM_VCS];
    logic                   cred_err_q, cred_err_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   p1_valid_q, p1_tail_q;
    logic [DEST_BITS-1:0]   p1_dest_q;
    logic [VC_BITS-1:0]     p1_vc_q;
    logic [FW-1:0]          flit_q;

    logic                   sel_found_s;
    logic [MW-1:0]          sel_idx_s;
    logic [DEST_BITS-1:0]   sel_dest_s;
    logic [VC_BITS-1:0]     sel_vc_s;
    logic [NUM_VCS-1:0]     vc_sel_s, vc_ok_s, ret_hit_s;
    logic                   credit_avail_s;
    logic                   issue_s;
    logic                   tail_s;

    // Mapper index reached by stepping 'step' places past the RR pointer.
    function automatic logic [MW-1:0] rr_cand(input logic [MW-1:0] ptr, input int step);
        int sum;
        sum = (int'(ptr) + step) % NUM_MAPPERS;
        return MW'(sum);
    endfunction

    // Round-robin search for the first free mapper after the pointer.
    always_comb begin
        sel_found_s = 1'b0;
        sel_idx_s   = rr_q;
        for (int k = 1; k <= NUM_MAPPERS; k++) begin
            if (!sel_found_s && mapper_free[rr_cand(rr_q, k)]) begin
                sel_found_s = 1'b1;
                sel_idx_s   = rr_cand(rr_q, k);
            end else begin
                sel_idx_s   = sel_idx_s;
            end
        end
        sel_dest_s = DEST_BITS'(MAPPER_PORT_BASE + int'(sel_idx_s));
        sel_vc_s   = VC_BITS'(int'(sel_idx_s) % NUM_VCS);
    end

    // Per-VC decode of the active VC, credit availability and credit returns.
    always_comb begin
        vc_sel_s  = '0;
        vc_ok_s   = '0;
        ret_hit_s = '0;
        for (int v = 0; v < NUM_VCS; v++) begin
            vc_sel_s[v]  = (vc_q == VC_BITS'(v));
            vc_ok_s[v]   = (credit_q[v] != {CW{1'b0}});
            // credit_vc values at or beyond NUM_VCS match no lane and are dropped
            ret_hit_s[v] = get_credit[VC_BITS] && (get_credit[VC_BITS-1:0] == VC_BITS'(v));
        end
        credit_avail_s = |(vc_sel_s & vc_ok_s);
        tail_s = (pkt_cnt_q == PKT_LAST) || (words_left_q == WL_ONE);
    end

    // FSM state register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start && (num_words != WL_ZERO)) begin
                    state_d = ST_SELECT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SELECT: begin
                if (sel_found_s) begin
                    state_d = ST_STREAM;
                end else begin
                    state_d = ST_SELECT;
                end
            end
            ST_STREAM: begin
                if (issue_s && tail_s) begin
                    state_d = (words_left_q != WL_ONE) ? ST_SELECT : ST_DRAIN;
                end else begin
                    state_d = ST_STREAM;
                end
            end
            ST_DRAIN: begin
                if (p1_valid_q) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM outputs: read issue, and next values of busy/done.
    always_comb begin
        issue_s = 1'b0;
        done_d  = 1'b0;
        busy_d  = busy_q;
        case (state_q)
            ST_IDLE: begin
                if (start && (num_words == WL_ZERO)) begin
                    done_d = 1'b1;
                    busy_d = 1'b0;
                end else if (start) begin
                    busy_d = 1'b1;
                end else begin
                    busy_d = 1'b0;
                end
            end
            ST_SELECT: busy_d = 1'b1;
            ST_STREAM: begin
                busy_d  = 1'b1;
                issue_s = (words_left_q != WL_ZERO) && credit_avail_s;
            end
            ST_DRAIN: begin
                if (p1_valid_q) begin
                    done_d = 1'b1;
                    busy_d = 1'b0;
                end else begin
                    busy_d = 1'b1;
                end
            end
            default: begin
                issue_s = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // Transfer bookkeeping: address, remaining words, packet position, routing.
    always_comb begin
        addr_d       = addr_q;
        words_left_d = words_left_q;
        pkt_cnt_d    = pkt_cnt_q;
        rr_d         = rr_q;
        dest_d       = dest_q;
        vc_d         = vc_q;
        if ((state_q == ST_IDLE) && start) begin
            addr_d       = base_addr;
            words_left_d = num_words;
        end else if ((state_q == ST_SELECT) && sel_found_s) begin
            rr_d      = sel_idx_s;
            dest_d    = sel_dest_s;
            vc_d      = sel_vc_s;
            pkt_cnt_d = {PCW{1'b0}};
        end else if (issue_s) begin
            addr_d       = addr_q + ADDR_ONE;
            words_left_d = words_left_q - WL_ONE;
            pkt_cnt_d    = pkt_cnt_q + PCW'(1);
        end else begin
            addr_d = addr_q;
        end
    end

    // Credit counters: reserve on issue, refill on return, saturate and flag overflow.
    always_comb begin
        cred_err_d = cred_err_q;
        for (int v = 0; v < NUM_VCS; v++) begin
            credit_d[v] = credit_q[v];
            if (ret_hit_s[v] && !(issue_s && vc_sel_s[v])) begin
                if (credit_q[v] == CRED_MAX) begin
                    cred_err_d = 1'b1;
                end else begin
                    credit_d[v] = credit_q[v] + CRED_ONE;
                end
            end else if (!ret_hit_s[v] && issue_s && vc_sel_s[v]) begin
                credit_d[v] = credit_q[v] - CRED_ONE;
            end else begin
                credit_d[v] = credit_q[v];
            end
        end
    end

    // Datapath and credit state registers.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            addr_q       <= {ADDR_WIDTH{1'b0}};
            words_left_q <= WL_ZERO;
            pkt_cnt_q    <= {PCW{1'b0}};
            rr_q         <= MW'(NUM_MAPPERS - 1);
            dest_q       <= {DEST_BITS{1'b0}};
            vc_q         <= {VC_BITS{1'b0}};
            cred_err_q   <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            for (int v = 0; v < NUM_VCS; v++) begin
                credit_q[v] <= CRED_MAX;
            end
        end else begin
            addr_q       <= addr_d;
            words_left_q <= words_left_d;
            pkt_cnt_q    <= pkt_cnt_d;
            rr_q         <= rr_d;
            dest_q       <= dest_d;
            vc_q         <= vc_d;
            cred_err_q   <= cred_err_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            for (int v = 0; v < NUM_VCS; v++) begin
                credit_q[v] <= credit_d[v];
            end
        end
    end

    // Read pipeline: carry flit header alongside the outstanding SRAM read,
    // then assemble the flit when the read data returns.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            p1_valid_q <= 1'b0;
            p1_tail_q  <= 1'b0;
            p1_dest_q  <= {DEST_BITS{1'b0}};
            p1_vc_q    <= {VC_BITS{1'b0}};
            flit_q     <= {FW{1'b0}};
        end else begin
            p1_valid_q <= issue_s;
            if (issue_s) begin
                p1_tail_q <= tail_s;
                p1_dest_q <= dest_q;
                p1_vc_q   <= vc_q;
            end else begin
                p1_tail_q <= p1_tail_q;
            end
            if (p1_valid_q) begin
                flit_q <= {1'b1, p1_tail_q, p1_dest_q, p1_vc_q, sram_rdata};
            end else begin
                flit_q[FW-1] <= 1'b0;
            end
        end
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign sram_en       = issue_s;
    assign sram_addr     = addr_q;
    assign flit_out      = flit_q;
    assign en_get_credit = 1'b1;
    assign cred_err      = cred_err_q;

endmodule

// File: tb/tb_noc_stream_injector.sv
// Self-checking bench for noc_stream_injector: randomized transfers checked
// against a packet-level reference model (round-robin mapper choice, packet
// splitting and SRAM contents computed directly from the transfer request).
`timescale 1ns/1ps
module tb_noc_stream_injector;
    localparam int DW = 32, AW = 10, NM = 4, DB = 2, NV = 2, VB = 1, CPV = 4, PL = 8;
    localparam int FW = 2 + DB + VB + DW;

    logic          CLK = 1'b0;
    logic          RST = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [AW:0]   num_words = '0;
    logic          busy, done, sram_en, en_get_credit, cred_err;
    logic [AW-1:0] sram_addr;
    logic [DW-1:0] sram_rdata = '0;
    logic [NM-1:0] mapper_free = '1;
    logic [FW-1:0] flit_out;
    logic [VB:0]   get_credit = '0;

    noc_stream_injector #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_MAPPERS(NM), .DEST_BITS(DB),
        .MAPPER_PORT_BASE(0), .NUM_VCS(NV), .VC_BITS(VB),
        .CREDITS_PER_VC(CPV), .PKT_LEN(PL)
    ) dut (
        .CLK(CLK), .RST(RST), .start(start), .base_addr(base_addr),
        .num_words(num_words), .busy(busy), .done(done), .sram_en(sram_en),
        .sram_addr(sram_addr), .sram_rdata(sram_rdata), .mapper_free(mapper_free),
        .flit_out(flit_out), .get_credit(get_credit), .en_get_credit(en_get_credit),
        .cred_err(cred_err)
    );

    always #5 CLK = ~CLK;

    // SRAM contents are a fixed function of the address.
    function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
        return {a, 6'h2B, a, 6'h15};
    endfunction

    // Synchronous-read SRAM model.
    always @(posedge CLK) begin
        if (sram_en) sram_rdata <= mem_word(sram_addr);
    end

    int errors = 0, checks = 0;
    int cyc = 0, issues = 0, dones = 0;
    int done_cyc = -1, last_issue_cyc = -1, first_issue_cyc = -1;
    int last_flit_cyc = -1, first_flit_cyc = -1;
    bit busy_seen = 0, auto_credit = 0;
    int m_rr = NM - 1;
    logic [FW-1:0] obs_q[$];
    logic [FW-1:0] exp_q[$];
    logic [AW-1:0] iss_addr_q[$];
    logic [VB-1:0] pend_q[$];

    // Reference model: first free mapper after the pointer.
    function automatic int pick(input int rr, input logic [NM-1:0] free);
        for (int k = 1; k <= NM; k++) begin
            if (free[(rr + k) % NM]) return (rr + k) % NM;
        end
        return 0;
    endfunction

    // Reference model: expected flit stream for one transfer.
    task automatic build_expected(input logic [AW-1:0] base, input int num, input logic [NM-1:0] free);
        int i, len, m;
        logic [AW-1:0] a;
        exp_q.delete();
        i = 0;
        while (i < num) begin
            m = pick(m_rr, free);
            m_rr = m;
            len = (num - i < PL) ? (num - i) : PL;
            for (int j = 0; j < len; j++) begin
                a = base + AW'(i + j);
                exp_q.push_back({1'b1, (j == len - 1), DB'(m), VB'(m % NV), mem_word(a)});
            end
            i += len;
        end
    endtask

    // One clock: sample outputs mid-cycle, then drive credit returns.
    task automatic step();
        logic [FW-1:0] f;
        @(negedge CLK);
        cyc++;
        if (sram_en) begin
            if (first_issue_cyc < 0) first_issue_cyc = cyc;
            issues++;
            last_issue_cyc = cyc;
            iss_addr_q.push_back(sram_addr);
        end
        f = flit_out;
        if (f[FW-1]) begin
            if (first_flit_cyc < 0) first_flit_cyc = cyc;
            obs_q.push_back(f);
            last_flit_cyc = cyc;
            if (auto_credit) pend_q.push_back(f[DW]);
        end
        if (done) begin
            dones++;
            done_cyc = cyc;
        end
        if (busy) busy_seen = 1;
        get_credit = '0;
        if (auto_credit && pend_q.size() > 0 && $urandom_range(0, 3) != 0)
            get_credit = {1'b1, pend_q.pop_front()};
    endtask

    task automatic clear_obs();
        obs_q.delete();
        iss_addr_q.delete();
        issues = 0; dones = 0; done_cyc = -1; last_issue_cyc = -1; first_issue_cyc = -1;
        last_flit_cyc = -1; first_flit_cyc = -1; busy_seen = 0;
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RST = 1'b1; start = 1'b0; get_credit = '0;
        pend_q.delete();
        @(negedge CLK);
        RST = 1'b0;
        m_rr = NM - 1;
        clear_obs();
    endtask

    task automatic pulse_start(input logic [AW-1:0] b, input int n);
        start = 1'b1; base_addr = b; num_words = (AW+1)'(n);
        step();
        start = 1'b0;
    endtask

    task automatic wait_done(input int bound, output bit to);
        for (int i = 0; i < bound && dones == 0; i++) step();
        to = (dones == 0);
    endtask

    task automatic settle();
        for (int i = 0; i < 200 && pend_q.size() > 0; i++) step();
        step();
    endtask

    task automatic test_reset();
        @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
        checks++; if (sram_en !== 1'b0) begin errors++; $display("FAIL reset_sram_en: got %b want 0", sram_en); end
        checks++; if (sram_addr !== '0) begin errors++; $display("FAIL reset_sram_addr: got %h want 0", sram_addr); end
        checks++; if (flit_out !== '0) begin errors++; $display("FAIL reset_flit: got %h want 0", flit_out); end
        checks++; if (cred_err !== 1'b0) begin errors++; $display("FAIL reset_cred_err: got %b want 0", cred_err); end
        checks++; if (en_get_credit !== 1'b1) begin errors++; $display("FAIL reset_en_credit: got %b want 1", en_get_credit); end
        RST = 1'b0;
        m_rr = NM - 1;
        clear_obs();
    endtask

    task automatic test_credit_stall();
        bit to;
        do_reset();
        auto_credit = 0; mapper_free = 4'b1111;
        build_expected(10'h010, 8, 4'b1111);
        pulse_start(10'h010, 8);
        repeat (25) step();
        checks++; if (issues !== 4) begin errors++; $display("FAIL stall_issues: got %0d want 4", issues); end
        checks++; if (obs_q.size() !== 4) begin errors++; $display("FAIL stall_flits: got %0d want 4", obs_q.size()); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (i >= iss_addr_q.size() || iss_addr_q[i] !== AW'(10'h010 + i)) begin
                errors++; $display("FAIL stall_addr[%0d]: got %h want %h", i,
                    (i < iss_addr_q.size()) ? iss_addr_q[i] : 'x, AW'(10'h010 + i));
            end
        end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL stall_busy: got %b want 1", busy); end
        checks++; if (first_flit_cyc !== first_issue_cyc + 2) begin errors++;
            $display("FAIL flit_latency: got flit cycle %0d want %0d", first_flit_cyc, first_issue_cyc + 2); end
        for (int k = 0; k < 4; k++) begin
            get_credit = 2'b10;
            step();
        end
        wait_done(60, to);
        checks++; if (to) begin errors++; $display("FAIL stall_done_timeout: got no done want done"); end
        checks++; if (obs_q.size() !== 8) begin errors++; $display("FAIL stall_total: got %0d want 8", obs_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin
                errors++; $display("FAIL stall_flit[%0d]: got %h want %h", i,
                    (i < obs_q.size()) ? obs_q[i] : 'x, exp_q[i]);
            end
        end
        checks++; if (done_cyc !== last_issue_cyc + 2) begin errors++;
            $display("FAIL stall_done_time: got cycle %0d want %0d", done_cyc, last_issue_cyc + 2); end
        repeat (3) step();
        checks++; if (dones !== 1 || busy !== 1'b0) begin errors++;
            $display("FAIL stall_after: got dones=%0d busy=%b want 1/0", dones, busy); end
    endtask

    task automatic test_multi_packet();
        bit to;
        logic [AW-1:0] b;
        do_reset();
        auto_credit = 1; mapper_free = 4'b1111;
        b = AW'($urandom_range(0, 1023));
        build_expected(b, 20, 4'b1111);
        pulse_start(b, 20);
        wait_done(400, to);
        checks++; if (to) begin errors++; $display("FAIL multi_done_timeout: got no done want done"); end
        checks++; if (obs_q.size() !== 20) begin errors++; $display("FAIL multi_count: got %0d want 20", obs_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin
                errors++; $display("FAIL multi_flit[%0d]: got %h want %h", i,
                    (i < obs_q.size()) ? obs_q[i] : 'x, exp_q[i]);
            end
        end
        if (obs_q.size() == 20) begin
            checks++;
            if ({obs_q[7][FW-2], obs_q[15][FW-2], obs_q[19][FW-2], obs_q[6][FW-2]} !== 4'b1110) begin
                errors++; $display("FAIL multi_tails: got %b want 1110",
                    {obs_q[7][FW-2], obs_q[15][FW-2], obs_q[19][FW-2], obs_q[6][FW-2]});
            end
            checks++;
            if ({obs_q[0][DW+VB+DB-1:DW], obs_q[8][DW+VB+DB-1:DW], obs_q[16][DW+VB+DB-1:DW]} !== 9'b000_011_100) begin
                errors++; $display("FAIL multi_route: got %b want 000011100",
                    {obs_q[0][DW+VB+DB-1:DW], obs_q[8][DW+VB+DB-1:DW], obs_q[16][DW+VB+DB-1:DW]});
            end
        end
        settle();
    endtask

    task automatic test_no_free();
        bit to;
        logic [AW-1:0] b;
        do_reset();
        auto_credit = 1; mapper_free = 4'b0000;
        b = AW'($urandom_range(0, 1023));
        pulse_start(b, 5);
        repeat (10) step();
        checks++; if (issues !== 0) begin errors++; $display("FAIL nofree_issues: got %0d want 0", issues); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL nofree_busy: got %b want 1", busy); end
        mapper_free = 4'b0100;
        build_expected(b, 5, 4'b0100);
        wait_done(100, to);
        checks++; if (to) begin errors++; $display("FAIL nofree_timeout: got no done want done"); end
        checks++;
        if (obs_q.size() == 0 || obs_q[0][DW+VB+DB-1:DW] !== 3'b100) begin
            errors++; $display("FAIL nofree_first_route: got %b want 100",
                (obs_q.size() > 0) ? obs_q[0][DW+VB+DB-1:DW] : 3'bxxx);
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin
                errors++; $display("FAIL nofree_flit[%0d]: got %h want %h", i,
                    (i < obs_q.size()) ? obs_q[i] : 'x, exp_q[i]);
            end
        end
        mapper_free = 4'b1111;
        settle();
    endtask

    task automatic test_credit_same_cycle();
        bit sent;
        do_reset();
        auto_credit = 0; mapper_free = 4'b1111; sent = 0;
        pulse_start(10'h000, 8);
        for (int i = 0; i < 25; i++) begin
            step();
            if (issues == 3 && !sent) begin
                get_credit = 2'b10;
                sent = 1;
            end
        end
        checks++; if (issues !== 5) begin errors++; $display("FAIL same_cycle_issues: got %0d want 5", issues); end
        checks++; if (cred_err !== 1'b0) begin errors++; $display("FAIL same_cycle_err: got %b want 0", cred_err); end
    endtask

    task automatic test_cred_sat();
        do_reset();
        auto_credit = 0; mapper_free = 4'b1111;
        get_credit = 2'b10;
        step();
        step();
        checks++; if (cred_err !== 1'b1) begin errors++; $display("FAIL sat_err: got %b want 1", cred_err); end
        pulse_start(10'h000, 8);
        repeat (25) step();
        checks++; if (issues !== 4) begin errors++; $display("FAIL sat_issues: got %0d want 4", issues); end
        checks++; if (cred_err !== 1'b1) begin errors++; $display("FAIL sat_sticky: got %b want 1", cred_err); end
    endtask

    task automatic test_zero_len();
        do_reset();
        auto_credit = 1;
        pulse_start(AW'($urandom_range(0, 1023)), 0);
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL zero_done: got %b want 1", done); end
        repeat (5) step();
        checks++; if (dones !== 1) begin errors++; $display("FAIL zero_done_count: got %0d want 1", dones); end
        checks++; if (busy_seen !== 1'b0) begin errors++; $display("FAIL zero_busy: got %b want 0", busy_seen); end
        checks++; if (issues !== 0) begin errors++; $display("FAIL zero_issues: got %0d want 0", issues); end
    endtask

    task automatic test_start_ignored();
        bit to;
        logic [AW-1:0] b;
        do_reset();
        auto_credit = 1; mapper_free = 4'b1111;
        b = AW'($urandom_range(0, 1023));
        build_expected(b, 12, 4'b1111);
        pulse_start(b, 12);
        repeat (3) step();
        pulse_start(b + AW'(5), 3);
        wait_done(300, to);
        checks++; if (to) begin errors++; $display("FAIL ignore_timeout: got no done want done"); end
        checks++; if (obs_q.size() !== 12) begin errors++; $display("FAIL ignore_count: got %0d want 12", obs_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin
                errors++; $display("FAIL ignore_flit[%0d]: got %h want %h", i,
                    (i < obs_q.size()) ? obs_q[i] : 'x, exp_q[i]);
            end
        end
        repeat (6) step();
        checks++; if (dones !== 1) begin errors++; $display("FAIL ignore_dones: got %0d want 1", dones); end
        settle();
    endtask

    task automatic test_async_reset();
        do_reset();
        auto_credit = 0; mapper_free = 4'b1111;
        pulse_start(10'h020, 16);
        repeat (3) step();
        checks++; if (busy !== 1'b1 || flit_out[FW-1] !== 1'b1) begin errors++;
            $display("FAIL areset_pre: got busy=%b valid=%b want 1/1", busy, flit_out[FW-1]); end
        #2;
        RST = 1'b1;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL areset_busy: got %b want 0", busy); end
        checks++; if (sram_en !== 1'b0) begin errors++; $display("FAIL areset_sram_en: got %b want 0", sram_en); end
        checks++; if (flit_out !== '0) begin errors++; $display("FAIL areset_flit: got %h want 0", flit_out); end
        checks++; if (sram_addr !== '0) begin errors++; $display("FAIL areset_addr: got %h want 0", sram_addr); end
        @(negedge CLK);
        RST = 1'b0;
        m_rr = NM - 1;
        pend_q.delete();
        clear_obs();
        build_expected(10'h030, 8, 4'b1111);
        pulse_start(10'h030, 8);
        repeat (25) step();
        checks++; if (issues !== 4) begin errors++; $display("FAIL areset_credits: got %0d issues want 4", issues); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin
                errors++; $display("FAIL areset_flit[%0d]: got %h want %h", i,
                    (i < obs_q.size()) ? obs_q[i] : 'x, exp_q[i]);
            end
        end
    endtask

    task automatic test_random();
        bit to;
        logic [AW-1:0] b;
        logic [NM-1:0] fr;
        int n;
        do_reset();
        auto_credit = 1;
        for (int t = 0; t < 8; t++) begin
            b  = (t == 2) ? 10'h3FA : AW'($urandom_range(0, 1023));
            n  = $urandom_range(1, 30);
            fr = NM'($urandom_range(1, 15));
            mapper_free = fr;
            clear_obs();
            build_expected(b, n, fr);
            pulse_start(b, n);
            wait_done(600, to);
            checks++; if (to) begin errors++; $display("FAIL rand%0d_timeout: got no done want done", t); end
            checks++; if (obs_q.size() !== exp_q.size()) begin errors++;
                $display("FAIL rand%0d_count: got %0d want %0d", t, obs_q.size(), exp_q.size()); end
            for (int i = 0; i < exp_q.size(); i++) begin
                checks++;
                if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin
                    errors++; $display("FAIL rand%0d_flit[%0d]: got %h want %h", t, i,
                        (i < obs_q.size()) ? obs_q[i] : 'x, exp_q[i]);
                end
            end
            checks++; if (done_cyc !== last_issue_cyc + 2 || last_flit_cyc !== done_cyc) begin errors++;
                $display("FAIL rand%0d_done_time: got done %0d flit %0d want %0d", t, done_cyc, last_flit_cyc, last_issue_cyc + 2); end
            settle();
        end
        mapper_free = 4'b1111;
    endtask

    initial begin
        test_reset();
        test_credit_stall();
        test_multi_packet();
        test_no_free();
        test_credit_same_cycle();
        test_cred_sat();
        test_zero_len();
        test_start_ignored();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish want finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/noc_stream_injector.md
Name: noc_stream_injector

Overview:
Parametrised SRAM-to-NoC injector. It streams a programmed address range out of the input SRAM and packs the words into NoC flits of fixed packet length. Each packet goes to a free mapper, chosen round-robin, on a per-mapper VC under per-VC credit flow control. It sits between the input SRAM and the NoC user send port, in front of the mapper array.

Parameters:
DATA_WIDTH, 32, SRAM word width = flit payload width
ADDR_WIDTH, 10, SRAM address width
NUM_MAPPERS, 4, number of mapper destinations (>=1)
DEST_BITS, 2, NoC destination field width
MAPPER_PORT_BASE, 0, NoC port of mapper 0; mapper i is at MAPPER_PORT_BASE+i
NUM_VCS, 2, virtual channels (>=1)
VC_BITS, 1, VC field width (1 when NUM_VCS==1)
CREDITS_PER_VC, 4, downstream buffer depth per VC
PKT_LEN, 8, flits per packet (>=1)

Ports:
CLK  in  1  clock
RST  in  1  asynchronous active-high reset
start  in  1  one-cycle pulse; launch a transfer when idle
base_addr  in  ADDR_WIDTH  first SRAM address, sampled on start
num_words  in  ADDR_WIDTH+1  words to send, sampled on start
busy  out  1  transfer in progress
done  out  1  one-cycle pulse at transfer end
sram_en  out  1  SRAM read enable
sram_addr  out  ADDR_WIDTH  SRAM read address
sram_rdata  in  DATA_WIDTH  read data, valid the cycle after sram_en
mapper_free  in  NUM_MAPPERS  bit i high = mapper i can accept a new packet
flit_out  out  2+DEST_BITS+VC_BITS+DATA_WIDTH  {valid, tail, dest, vc, data}
get_credit  in  VC_BITS+1  {credit_valid, credit_vc}; one returned credit
en_get_credit  out  1  credit-accept enable; constant 1 out of reset
cred_err  out  1  sticky: credit returned to a full counter

Behaviour:
- Reset values: busy=0, done=0, sram_en=0, sram_addr=0, flit_out=0, cred_err=0. en_get_credit=1. All credit counters = CREDITS_PER_VC. Round-robin pointer = NUM_MAPPERS-1, so mapper 0 wins first. FSM = IDLE. Reset mid-transfer aborts immediately; no tail is emitted.
- FSM IDLE -> SELECT on start. If num_words==0, pulse done the next cycle and stay IDLE; busy is not asserted. start is ignored while busy.
- SELECT: pick the first free mapper after the RR pointer, wrapping modulo NUM_MAPPERS. Latch dest=MAPPER_PORT_BASE+idx and vc=idx mod NUM_VCS. Update the pointer to idx. Go to STREAM. If no mapper is free, stay in SELECT with no read issued.
- STREAM: each cycle, issue when words remain, the packet is not finished, and credit[vc]>0. Issue = sram_en=1 with sram_addr = current address; address++ and words_left-- with it.
  - Credits are reserved at issue. credit[vc] drops by 1 that cycle.
  - Throughput: one flit per cycle when credits allow.
- Latency: an issue at cycle t puts flit_out at t+2 with valid=1, data=sram_rdata, and dest/vc latched at issue. valid is high for exactly one cycle per flit. Otherwise flit_out.valid=0 and the other fields are held.
- tail=1 on the PKT_LEN-th flit of a packet or on the final word of the transfer. After a tail is issued: return to SELECT if words remain, else go to DRAIN.
- DRAIN: wait until the last flit has appeared on flit_out, then pulse done for one cycle together with busy->0, and go to IDLE.
- Credit return: credit_valid increments credit[credit_vc].
  - A return and an issue on the same VC in the same cycle leave the count unchanged.
  - A return to a counter at CREDITS_PER_VC saturates and sets cred_err; cred_err is cleared only by RST.
  - credit_vc >= NUM_VCS is ignored.
- The address wraps modulo 2^ADDR_WIDTH.
- mapper_free is sampled only in SELECT. A mapper going busy mid-packet does not affect the packet.

Test Plan:
- RST, then start with base=0x10, num=8, PKT_LEN=8, all mappers free, no credit returns. Required: 4 flits to port 0/vc0 (addr 0x10-0x13), then a stall. Return 4 credits on vc0: remaining flits follow, tail on flit 8, done 2 cycles after the last issue.
- num=20, PKT_LEN=8, mapper_free=4'b1111, unlimited credit returns. Required: packets of 8/8/4 to mappers 0,1,2 on vc 0,1,0, tails on flits 8, 16 and 20.
- mapper_free=4'b0000 for 10 cycles, then 4'b0100. Required: no sram_en while none are free; first packet goes to port 2, vc 0.
- Credit return and issue on vc0 in the same cycle with count=2 -> count stays 2. A return with count=4 -> count stays 4 and cred_err=1.
- num=0 -> done one cycle after start, busy never high. start pulsed while busy -> ignored.
- RST asserted mid-packet, asynchronously between clock edges. Required: outputs clear immediately; credits back to 4; a new transfer starts cleanly at mapper 0.
